// File: rtl/tour_length_checker.sv
// tour_length_checker: snapshots a solver path on request, then walks it one
// edge per cycle. It reports the closed-tour Manhattan length and whether the
// path is a permutation of 0..N-1, with the first offending position.
//
// Handshake: start is a request sampled only in IDLE; the accepting edge
// raises busy. done is a one-cycle pulse exactly N cycles after acceptance.
// busy falls on the following edge. start while busy is dropped, not queued.
module tour_length_checker #(
   parameter int N     = 64,
   parameter int W     = 32,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
   parameter int LEN_W = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     xs [N],
   input  logic [W-1:0]     ys [N],
   input  logic [W-1:0]     path [N],
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] tour_len,
   output logic             valid_perm,
   output logic [IDX_W-1:0] err_idx,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [W-1:0]     N_W  = W'(N);

   state_t           state, state_nx;
   logic [W-1:0]     snap [N];
   logic [N-1:0]     seen;
   logic [LEN_W-1:0] acc;
   logic             err_flag;
   logic [IDX_W-1:0] err_pos;
   logic [IDX_W-1:0] k;

   // Per-edge combinational datapath
   logic [IDX_W-1:0] k_nx;
   logic [W-1:0]     a_val, b_val;
   logic             a_ok, b_ok;
   logic [IDX_W-1:0] a_idx, b_idx;
   logic [W:0]       dx, dy, ndx, ndy;
   logic [W-1:0]     adx, ady;
   logic [W:0]       edge_len;
   logic             cur_err;
   logic [LEN_W-1:0] acc_sum;

   // Done is the FIN state itself, so it is a clean one-cycle pulse.
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign dbg_state = state;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state logic: WALK lasts exactly N cycles, FIN exactly one
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = WALK;
         WALK:    if (k == LAST) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Edge k -> k+1 (wrapping) length and position-k error detection
   always_comb begin
      k_nx  = (k == LAST) ? '0 : k + 1'b1;
      a_val = snap[k];
      b_val = snap[k_nx];
      a_ok  = (a_val < N_W);
      b_ok  = (b_val < N_W);
      // Out-of-range entries are steered to index 0. The edge is zeroed
      // anyway, and this keeps the array reads in bounds.
      a_idx = a_ok ? a_val[IDX_W-1:0] : '0;
      b_idx = b_ok ? b_val[IDX_W-1:0] : '0;
      dx    = {1'b0, xs[a_idx]} - {1'b0, xs[b_idx]};
      dy    = {1'b0, ys[a_idx]} - {1'b0, ys[b_idx]};
      ndx   = -dx;
      ndy   = -dy;
      adx   = dx[W] ? ndx[W-1:0] : dx[W-1:0];
      ady   = dy[W] ? ndy[W-1:0] : dy[W-1:0];
      edge_len = (a_ok && b_ok) ? ({1'b0, adx} + {1'b0, ady}) : '0;
      cur_err  = !a_ok || seen[a_idx];
      acc_sum  = acc + LEN_W'(edge_len);
   end

   // Snapshot, walk accumulation and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) snap[i] <= '0;
         seen       <= '0;
         acc        <= '0;
         err_flag   <= 1'b0;
         err_pos    <= '0;
         k          <= '0;
         tour_len   <= '0;
         valid_perm <= 1'b0;
         err_idx    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  snap     <= path;
                  seen     <= '0;
                  acc      <= '0;
                  err_flag <= 1'b0;
                  err_pos  <= '0;
                  k        <= '0;
               end
            end
            WALK: begin
               acc <= acc_sum;
               if (a_ok) seen[a_idx] <= 1'b1;
               // Only the first offending position is kept
               if (cur_err && !err_flag) begin
                  err_flag <= 1'b1;
                  err_pos  <= k;
               end
               k <= k_nx;
               // The last edge and last position fold straight into the results
               if (k == LAST) begin
                  tour_len   <= acc_sum;
                  valid_perm <= !(err_flag || cur_err);
                  err_idx    <= err_flag ? err_pos : (cur_err ? k : '0);
               end
            end
            FIN: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule
